// File: rtl/prog_sync_delay_if.sv
// Handshake-free data/control bundle for prog_sync_delay.
// master: en, din, din_valid, delay out; dout, dout_valid, primed, cur_delay in.
interface prog_sync_delay_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DW         = 5
);
  logic                  en;
  logic [DATA_WIDTH-1:0] din;
  logic                  din_valid;
  logic [DW-1:0]         delay;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  primed;
  logic [DW-1:0]         cur_delay;

  modport master (
    output en, din, din_valid, delay,
    input  dout, dout_valid, primed, cur_delay
  );

  modport slave (
    input  en, din, din_valid, delay,
    output dout, dout_valid, primed, cur_delay
  );
endinterface

// File: rtl/prog_sync_delay.sv
// Runtime-programmable clock-enabled delay line with valid tracking.
// Ports: clk, rst (async high), bus (slave: en/din/din_valid/delay in; dout/dout_valid/primed/cur_delay out).
module prog_sync_delay #(
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_DELAY   = 16,
  parameter int RESET_DELAY = 1
) (
  input logic              clk,
  input logic              rst,
  prog_sync_delay_if.slave bus
);
  localparam int DW = $clog2(MAX_DELAY + 1);
  // Output register is the last stage, so only MAX_DELAY-1 taps are stored.
  localparam int SD = (MAX_DELAY > 1) ? MAX_DELAY - 1 : 1;
  localparam int RD = (RESET_DELAY < 1) ? 1 :
                      (RESET_DELAY > MAX_DELAY) ? MAX_DELAY : RESET_DELAY;
  localparam logic [DW-1:0] RD_W  = DW'(RD);
  localparam logic [DW-1:0] MAX_W = DW'(MAX_DELAY);

  logic [DATA_WIDTH-1:0] dat_q [SD];
  logic [SD-1:0]         vld_q, vld_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dvld_q, dvld_d;
  logic                  prim_q, prim_d;
  logic [DW-1:0]         cur_q, cur_d;
  logic [DW-1:0]         cnt_q, cnt_d;
  logic [DW-1:0]         dreq;
  logic                  chg;
  logic [DATA_WIDTH-1:0] tap_data;
  logic                  tap_vld;

  always_comb begin
    dreq = bus.delay;
    if (bus.delay == '0) begin
      dreq = DW'(1);
    end else if (bus.delay > MAX_W) begin
      dreq = MAX_W;
    end
  end

  assign chg = (dreq != cur_q);

  // Tap D-1: din itself for D=1, else stored stage D-2.
  always_comb begin
    tap_data = bus.din;
    tap_vld  = bus.din_valid;
    for (int i = 0; i < SD; i++) begin
      if (cur_q == DW'(i + 2)) begin
        tap_data = dat_q[i];
        tap_vld  = vld_q[i];
      end
    end
  end

  always_comb begin
    vld_d  = vld_q;
    dout_d = dout_q;
    dvld_d = dvld_q;
    prim_d = prim_q;
    cur_d  = cur_q;
    cnt_d  = cnt_q;
    if (bus.en) begin
      if (chg) begin
        // Flush: only the sample taken on this edge survives.
        vld_d    = '0;
        vld_d[0] = bus.din_valid;
        dvld_d   = 1'b0;
        prim_d   = 1'b0;
        cnt_d    = '0;
        cur_d    = dreq;
      end else begin
        vld_d[0] = bus.din_valid;
        for (int i = 1; i < SD; i++) begin
          vld_d[i] = vld_q[i-1];
        end
        dout_d = tap_data;
        dvld_d = tap_vld;
        if (cnt_q != cur_q) begin
          cnt_d = cnt_q + DW'(1);
        end
        prim_d = (cnt_d == cur_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      dout_q <= '0;
      dvld_q <= 1'b0;
      prim_q <= 1'b0;
      cur_q  <= RD_W;
      cnt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      dout_q <= dout_d;
      dvld_q <= dvld_d;
      prim_q <= prim_d;
      cur_q  <= cur_d;
      cnt_q  <= cnt_d;
    end
  end

  // Stage data is qualified by vld_q, so it carries no reset.
  always_ff @(posedge clk) begin
    if (bus.en && !rst) begin
      dat_q[0] <= bus.din;
      for (int i = 1; i < SD; i++) begin
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dvld_q;
  assign bus.primed     = prim_q;
  assign bus.cur_delay  = cur_q;
endmodule

// File: tb/tb_prog_sync_delay.sv
// Self-checking bench for prog_sync_delay.
// Table vectors plus a due-time scoreboard of in-flight samples.
module tb_prog_sync_delay;
  localparam int DWD = 32;
  localparam int MAXD = 16;
  localparam int DW = 5;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  prog_sync_delay_if #(.DATA_WIDTH(DWD), .DW(DW)) bus ();

  prog_sync_delay #(
    .DATA_WIDTH(DWD),
    .MAX_DELAY(MAXD),
    .RESET_DELAY(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        v;
    int          due;
  } sb_t;

  typedef struct {
    logic [31:0] din;
    logic        dv;
    logic        exp_dv;
    logic        exp_pr;
    logic        chk_dout;
    logic [31:0] exp_dout;
  } vec_t;

  sb_t         sb[$];
  int          qe;
  logic [4:0]  m_cur;
  int          m_cnt;
  logic        m_prim;
  logic        m_dv;
  logic [31:0] m_dout;
  logic        m_known;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] clampd(input logic [4:0] x);
    if (x == 5'd0) return 5'd1;
    if (x > 5'(MAXD)) return 5'(MAXD);
    return x;
  endfunction

  task automatic model_reset();
    m_cur   = 5'd1;
    m_cnt   = 0;
    m_prim  = 1'b0;
    m_dv    = 1'b0;
    m_dout  = '0;
    m_known = 1'b1;
    sb.delete();
  endtask

  task automatic model_edge(input logic [31:0] d, input logic v,
                            input logic [4:0] dl);
    logic [4:0] dr;
    sb_t e;
    qe++;
    dr = clampd(dl);
    if (dr != m_cur) begin
      m_cur  = dr;
      sb.delete();
      m_cnt  = 0;
      m_prim = 1'b0;
      m_dv   = 1'b0;
      if (dr > 5'd1) sb.push_back('{d, v, qe + int'(dr) - 1});
    end else begin
      sb.push_back('{d, v, qe + int'(m_cur) - 1});
      if (sb.size() > 0 && sb[0].due == qe) begin
        e = sb.pop_front();
        m_dout  = e.d;
        m_dv    = e.v;
        m_known = 1'b1;
      end else begin
        m_dv    = 1'b0;
        m_known = 1'b0;
      end
      if (m_cnt < int'(m_cur)) m_cnt++;
      m_prim = (m_cnt == int'(m_cur));
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".dout_valid"}, 32'(bus.dout_valid), 32'(m_dv));
    chk({tag, ".primed"}, 32'(bus.primed), 32'(m_prim));
    chk({tag, ".cur_delay"}, 32'(bus.cur_delay), 32'(m_cur));
    if (m_known) chk({tag, ".dout"}, bus.dout, m_dout);
  endtask

  task automatic step(input logic e, input logic [31:0] d, input logic v,
                      input logic [4:0] dl, input string tag);
    @(negedge clk);
    bus.en        = e;
    bus.din       = d;
    bus.din_valid = v;
    bus.delay     = dl;
    @(posedge clk);
    if (!rst && e) model_edge(d, v, dl);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 32'hDEAD_0000 + 32'(i), 1'b1, 5'd9, {tag, "_hold"});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    logic [31:0] ctr;
    logic [31:0] w;
    int dl_list[4];

    tbl[0] = '{32'hB000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{32'hB000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[2] = '{32'hB000_0002, 1'b1, 1'b1, 1'b0, 1'b1, 32'hB000_0000};
    tbl[3] = '{32'hB000_0003, 1'b1, 1'b0, 1'b1, 1'b1, 32'hB000_0001};
    tbl[4] = '{32'hB000_0004, 1'b0, 1'b1, 1'b1, 1'b1, 32'hB000_0002};
    tbl[5] = '{32'hB000_0005, 1'b0, 1'b1, 1'b1, 1'b1, 32'hB000_0003};
    tbl[6] = '{32'hB000_0006, 1'b0, 1'b0, 1'b1, 1'b1, 32'hB000_0004};
    tbl[7] = '{32'hB000_0007, 1'b0, 1'b0, 1'b1, 1'b1, 32'hB000_0005};
    dl_list = '{1, 2, 7, 16};

    n_chk  = 0;
    n_fail = 0;
    qe     = 0;
    bus.en        = 1'b0;
    bus.din       = '0;
    bus.din_valid = 1'b0;
    bus.delay     = 5'd1;
    rst = 1'b1;
    #3;
    model_reset();
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    ctr = 32'h1;
    foreach (dl_list[j]) begin
      for (int i = 0; i < dl_list[j] + 9; i++) begin
        step(1'b1, ctr, 1'b1, 5'(dl_list[j]), $sformatf("sweep_d%0d", dl_list[j]));
        ctr++;
      end
    end

    w = 32'hA5A5_0001;
    for (int i = 0; i < 32; i++) begin
      step((i % 4 == 0) || (i % 4 == 3), w, 1'b1, 5'd4, "stall");
      w++;
    end
    step(1'b0, w, 1'b1, 5'd9, "en0_chg");
    chk("en0_chg_ignored", 32'(bus.cur_delay), 32'd4);
    step(1'b1, w + 1, 1'b1, 5'd4, "en0_chg_after");

    foreach (tbl[i]) begin
      step(1'b1, tbl[i].din, tbl[i].dv, 5'd3, "vgap");
      chk($sformatf("tbl%0d.dv", i), 32'(bus.dout_valid), 32'(tbl[i].exp_dv));
      chk($sformatf("tbl%0d.pr", i), 32'(bus.primed), 32'(tbl[i].exp_pr));
      if (tbl[i].chk_dout) begin
        chk($sformatf("tbl%0d.dout", i), bus.dout, tbl[i].exp_dout);
      end
    end

    for (int i = 0; i < 20; i++) begin
      step(1'b1, 32'hC000_0000 + 32'(i), 1'b1, 5'd8, "d8_stream");
    end
    w = 32'hCC00_0000;
    step(1'b1, w, 1'b1, 5'd3, "d8to3_edge");
    chk("chg.dv_low", 32'(bus.dout_valid), 32'd0);
    chk("chg.primed_low", 32'(bus.primed), 32'd0);
    step(1'b1, w + 1, 1'b1, 5'd3, "d3_e1");
    chk("chg.e1_dv_low", 32'(bus.dout_valid), 32'd0);
    step(1'b1, w + 2, 1'b1, 5'd3, "d3_e2");
    chk("chg.first_dv", 32'(bus.dout_valid), 32'd1);
    chk("chg.first_word", bus.dout, w);
    for (int i = 3; i < 10; i++) begin
      step(1'b1, w + 32'(i), 1'b1, 5'd3, "d3_stream");
    end

    for (int i = 0; i < 6; i++) begin
      step(1'b1, 32'hD000_0000 + 32'(i), 1'b1, 5'd0, "clamp0");
    end
    chk("clamp0.cur", 32'(bus.cur_delay), 32'd1);
    for (int i = 0; i < 22; i++) begin
      step(1'b1, 32'hD100_0000 + 32'(i), 1'b1, 5'(MAXD + 5), "clamp_hi");
    end
    chk("clamp_hi.cur", 32'(bus.cur_delay), 32'(MAXD));

    step(1'b1, 32'hE000_0000, 1'b1, 5'd5, "back_a");
    step(1'b1, 32'hE000_0001, 1'b1, 5'(MAXD), "back_b");
    chk("back.primed_low", 32'(bus.primed), 32'd0);
    for (int i = 2; i < 8; i++) begin
      step(1'b1, 32'hE000_0000 + 32'(i), 1'b1, 5'(MAXD), "back_stream");
    end

    do_reset("midreset");
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 32'hF000_0000 + 32'(i), 1'b1, 5'd2, "post_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
